exp_series_top: RTL

Iterative fixed-point exponential calculator, the inverse of the ln(1+x) series unit. It evaluates exp(y) by Maclaurin series using one shared multiplier and a reciprocal table. It uses the same start/done handshake and bus widths as the ln unit, so the two can be chained for round-trip checks (exp(ln(1+x)) ≈ 1+x). The block sits beside the ln unit under the same controller.

---
 rtl/exp_series_pkg.sv | 43 ++++
 rtl/exp_series_mul.sv | 16 +
 rtl/exp_series_top.sv | 118 +++++++++++
 3 files changed

// File: rtl/exp_series_pkg.sv
// Shared definitions for the iterative exp(y) Maclaurin-series unit.
// Holds the fixed-point format widths, the FSM state type and the
// reciprocal ROM used to divide each term by its index k.
package exp_series_pkg;

    localparam int unsigned Y_W     = 16;  // argument, Q0.16
    localparam int unsigned T_W     = 20;  // series term, Q0.20
    localparam int unsigned A_W     = 22;  // accumulator, Q2.20
    localparam int unsigned R_W     = 18;  // result, Q2.16
    localparam int unsigned K_W     = 4;   // term index counter
    localparam int unsigned RECIP_W = 17;  // reciprocal, Q1.16
    localparam int unsigned P_W     = T_W + RECIP_W;

    typedef enum logic [2:0] {
        StIdle,
        StMulY,
        StMulR,
        StAcc,
        StDone
    } state_e;

    // round(2^16 / k) in Q1.16 for k = 1..12; other indices are never used.
    function automatic logic [RECIP_W-1:0] recip(input logic [K_W-1:0] k);
        logic [RECIP_W-1:0] r;
        case (k)
            4'd1:    r = 17'h10000;
            4'd2:    r = 17'h08000;
            4'd3:    r = 17'h05555;
            4'd4:    r = 17'h04000;
            4'd5:    r = 17'h03333;
            4'd6:    r = 17'h02AAB;
            4'd7:    r = 17'h02492;
            4'd8:    r = 17'h02000;
            4'd9:    r = 17'h01C72;
            4'd10:   r = 17'h0199A;
            4'd11:   r = 17'h01746;
            4'd12:   r = 17'h01555;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exp_series_mul.sv
// Combinational 20x17 unsigned multiplier shared by both multiply steps.
// Ports:
//   a - multiplicand (series term, Q0.20)
//   b - multiplier (zero-extended y or a reciprocal)
//   p - full 37-bit product
module exp_series_mul
    import exp_series_pkg::*;
(
    input  logic [T_W-1:0]     a,
    input  logic [RECIP_W-1:0] b,
    output logic [P_W-1:0]     p
);

    assign p = P_W'(a) * P_W'(b);

endmodule

// File: rtl/exp_series_top.sv
// Iterative exp(y) evaluator: 1 + sum_{k=1..TERMS} y^k / k!, built from the
// recurrence term_k = term_{k-1} * y / k with one shared multiplier.
// Three cycles per term (multiply by y, multiply by 1/k, accumulate).
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   start    - request, accepted only when idle or done
//   yBus     - argument y, Q0.16, captured on an accepted start
//   rBus     - exp(y), Q2.16, held until the next result
//   done     - level, high while a result is valid
//   busy     - high while a computation is in progress
module exp_series_top
    import exp_series_pkg::*;
#(
    parameter int unsigned TERMS = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [Y_W-1:0] yBus,
    output logic [R_W-1:0] rBus,
    output logic           done,
    output logic           busy
);

    localparam logic [T_W-1:0] TermOne = '1;          // 1.0 saturated in Q0.20
    localparam logic [A_W-1:0] AccOne  = 22'h100000;  // 1.0 in Q2.20

    state_e         state_q, state_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [T_W-1:0] term_q, term_d;
    logic [A_W-1:0] acc_q, acc_d;
    logic [K_W-1:0] k_q, k_d;
    logic [R_W-1:0] r_q, r_d;

    logic [RECIP_W-1:0] mul_b;
    logic [P_W-1:0]     mul_p;
    logic [A_W:0]       fin_sum;
    logic [A_W-4:0]     fin_res;
    logic               unused_mul;

    exp_series_mul u_mul (
        .a(term_q),
        .b(mul_b),
        .p(mul_p)
    );

    // Top product bit and low bits are dropped by the truncating rescale.
    assign unused_mul = ^{mul_p[P_W-1], mul_p[15:0]};

    // Final sum with round-half-up from Q2.20 to Q2.16; one guard bit for saturation.
    assign fin_sum = {1'b0, acc_q} + {{(A_W + 1 - T_W){1'b0}}, term_q} + (A_W + 1)'(8);
    assign fin_res = fin_sum[A_W:4];

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        term_d  = term_q;
        acc_d   = acc_q;
        k_d     = k_q;
        r_d     = r_q;
        mul_b   = {1'b0, y_q};
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StMulY;
                    y_d     = yBus;
                    term_d  = TermOne;
                    acc_d   = AccOne;
                    k_d     = 4'd1;
                end
            end
            StMulY: begin
                mul_b   = {1'b0, y_q};
                term_d  = mul_p[35:16];
                state_d = StMulR;
            end
            StMulR: begin
                mul_b   = recip(k_q);
                term_d  = mul_p[35:16];
                state_d = StAcc;
            end
            StAcc: begin
                acc_d = acc_q + A_W'(term_q);
                k_d   = k_q + 4'd1;
                if (k_q == K_W'(TERMS)) begin
                    r_d     = fin_res[R_W] ? '1 : fin_res[R_W-1:0];
                    state_d = StDone;
                end else begin
                    state_d = StMulY;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            y_q     <= '0;
            term_q  <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            term_q  <= term_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            r_q     <= r_d;
        end
    end

    assign rBus = r_q;
    assign done = (state_q == StDone);
    assign busy = (state_q == StMulY) || (state_q == StMulR) || (state_q == StAcc);

endmodule
